// File: rtl/ccsds123_out_fifo.sv
// rtl/ccsds123_out_fifo.sv - elastic output buffer behind ccsds123_top
// Accepts words with no backpressure and re-issues them as an AXI4-Stream master.
module ccsds123_out_fifo #(
  parameter int BUS_WIDTH = 64,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4,
  parameter int FCNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [BUS_WIDTH-1:0]       in_tdata,
  input  logic                       in_tvalid,
  input  logic                       in_tlast,
  output logic [BUS_WIDTH-1:0]       out_tdata,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic                       out_tlast,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [FCNT_W-1:0]          frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Storage behind the output register; the output register itself counts in level.
  logic [BUS_WIDTH-1:0] mem_data [DEPTH];
  logic                 mem_last [DEPTH];

  logic [LW-1:0] rd_ptr;
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] level_next;
  logic          push;
  logic          pop;
  logic          mem_empty;
  logic          load_out;
  logic          mem_write;

  assign out_tvalid = (level != '0);
  assign push       = in_tvalid && (level != LW'(DEPTH));
  assign pop        = out_tvalid && out_tready;
  assign mem_empty  = (level <= LW'(1));
  assign load_out   = pop || (level == '0);
  // Words bypass storage only when the output register is being refilled from nothing.
  assign mem_write  = push && !(load_out && mem_empty);
  assign level_next = level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem_data[wr_ptr[AW-1:0]] <= in_tdata;
      mem_last[wr_ptr[AW-1:0]] <= in_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
      out_tdata   <= '0;
      out_tlast   <= 1'b0;
    end else begin
      level       <= level_next;
      almost_full <= (level_next >= LW'(DEPTH - AF_MARGIN));
      if (in_tvalid && !push)
        overflow <= 1'b1;
      if (pop && out_tlast)
        frame_count <= frame_count + 1'b1;
      if (mem_write)
        wr_ptr <= wr_ptr + 1'b1;
      if (load_out && !mem_empty) begin
        out_tdata <= mem_data[rd_ptr[AW-1:0]];
        out_tlast <= mem_last[rd_ptr[AW-1:0]];
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (load_out && push) begin
        out_tdata <= in_tdata;
        out_tlast <= in_tlast;
      end
    end
  end

endmodule
